epu_axi_slave: RTL and testbench

AXI4 slave front end for the EPU. Accepts read/write bursts from the system bus and converts them into the EPU-side strobe/address/data bundle carried by `inf_EPUIN` (modport `EPUin`), and returns EPU read data on the R channel. It sits directly upstream of the EPU core: everything the core sees on `inf_EPUIN` is driven here.

---
 rtl/epu_axi_slave_if.sv | 64 ++++++
 rtl/epu_axi_slave.sv | 174 +++++++++++++++++
 tb/tb_epu_axi_slave.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epu_axi_slave_if.sv
// Bus bundles for epu_axi_slave: the AXI4 slave port and the EPU-side
// strobe/address/data bundle (inf_EPUIN). EPU_ADDR_BITS sets the default
// EPU word-address width.
`ifndef EPU_ADDR_BITS
`define EPU_ADDR_BITS 16
`endif

interface epu_axi_if #(parameter int IDW = 8);
    logic [IDW-1:0] AWID;
    logic [31:0]    AWADDR;
    logic [3:0]     AWLEN;
    logic [2:0]     AWSIZE;
    logic [1:0]     AWBURST;
    logic           AWVALID, AWREADY;
    logic [IDW-1:0] ARID;
    logic [31:0]    ARADDR;
    logic [3:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           ARVALID, ARREADY;
    logic [31:0]    WDATA;
    logic [3:0]     WSTRB;
    logic           WLAST, WVALID, WREADY;
    logic [IDW-1:0] BID;
    logic [1:0]     BRESP;
    logic           BVALID, BREADY;
    logic [IDW-1:0] RID;
    logic [31:0]    RDATA;
    logic [1:0]     RRESP;
    logic           RLAST, RVALID, RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BID, BRESP, BVALID, output BREADY,
        input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );
    modport slave (
        input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

interface epu_in_if #(parameter int EPU_AW = `EPU_ADDR_BITS);
    logic              CS, OE, arhns, awhns, whns, rhns, rdfin, wrfin;
    logic [EPU_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       epu_rdata;

    // EPUin: the front end driving the EPU core
    modport EPUin (
        output CS, OE, arhns, awhns, whns, rhns, rdfin, wrfin, addr, wdata,
        input  epu_rdata
    );
    // EPUcore: the EPU core consuming the bundle
    modport EPUcore (
        input  CS, OE, arhns, awhns, whns, rhns, rdfin, wrfin, addr, wdata,
        output epu_rdata
    );
endinterface

// File: rtl/epu_axi_slave.sv
// AXI4 slave front end for the EPU: turns AXI bursts into EPU strobes,
// word address and write data, and returns EPU read data on R.
// Optional macro EPU_SLVERR_EN: non-INCR or non-32-bit bursts get SLVERR
// and never reach the EPU.
module epu_axi_slave #(
    parameter int IDW    = 8,
    parameter int EPU_AW = `EPU_ADDR_BITS
) (
    input  logic      ACLK,
    input  logic      ARESETn,
    epu_axi_if.slave  axi,
    epu_in_if.EPUin   inf_EPUIN
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WDATA = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [EPU_AW-1:0] addr_q, addr_d;
    logic              first_q, first_d;   // arhns/awhns still owed for this burst
    logic              err_q, err_d;       // burst is answered with SLVERR
    logic              rfirst_q, rfirst_d; // first RDATA cycle: epu_rdata is live
    logic [31:0]       rdata_q, rdata_d;   // beat data held while RREADY is low

    logic ar_err, aw_err, ok;
    logic st_idle, st_ra, st_rd, st_w, st_b;
    logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
    logic [31:0] rd_out;
    logic unused_ok;

`ifdef EPU_SLVERR_EN
    assign ar_err    = (axi.ARBURST != 2'b01) || (axi.ARSIZE != 3'b010);
    assign aw_err    = (axi.AWBURST != 2'b01) || (axi.AWSIZE != 3'b010);
    assign unused_ok = ^{axi.WSTRB, axi.AWLEN,
                         axi.AWADDR[31:EPU_AW+2], axi.AWADDR[1:0],
                         axi.ARADDR[31:EPU_AW+2], axi.ARADDR[1:0]};
`else
    assign ar_err    = 1'b0;
    assign aw_err    = 1'b0;
    assign unused_ok = ^{axi.WSTRB, axi.AWLEN, axi.AWSIZE, axi.AWBURST,
                         axi.ARSIZE, axi.ARBURST,
                         axi.AWADDR[31:EPU_AW+2], axi.AWADDR[1:0],
                         axi.ARADDR[31:EPU_AW+2], axi.ARADDR[1:0]};
`endif

    assign st_idle = (state_q == IDLE);
    assign st_ra   = (state_q == RADDR);
    assign st_rd   = (state_q == RDATA);
    assign st_w    = (state_q == WDATA);
    assign st_b    = (state_q == WRESP);
    assign ok      = ~err_q;

    // write wins when both address channels are valid in IDLE
    assign aw_hs = st_idle & axi.AWVALID;
    assign ar_hs = st_idle & ~axi.AWVALID & axi.ARVALID;
    assign w_hs  = st_w & axi.WVALID;
    assign r_hs  = st_rd & axi.RREADY;
    assign b_hs  = st_b & axi.BREADY;

    assign rd_out = err_q ? 32'h0 : (rfirst_q ? inf_EPUIN.epu_rdata : rdata_q);

    // next-state and burst bookkeeping
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        first_d  = first_q;
        err_d    = err_q;
        rfirst_d = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = WDATA;
                    id_d    = axi.AWID;
                    addr_d  = axi.AWADDR[EPU_AW+1:2];
                    first_d = 1'b1;
                    err_d   = aw_err;
                end else if (ar_hs) begin
                    state_d = RADDR;
                    id_d    = axi.ARID;
                    cnt_d   = axi.ARLEN;
                    addr_d  = axi.ARADDR[EPU_AW+1:2];
                    first_d = 1'b1;
                    err_d   = ar_err;
                end
            end
            RADDR: begin
                state_d  = RDATA;
                first_d  = 1'b0;
                rfirst_d = 1'b1;
            end
            RDATA: begin
                if (rfirst_q)
                    rdata_d = rd_out;
                if (r_hs) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        addr_d  = addr_q + EPU_AW'(1);
                        state_d = RADDR;
                    end
                end
            end
            WDATA: begin
                first_d = 1'b0;
                if (w_hs) begin
                    addr_d = addr_q + EPU_AW'(1);
                    if (axi.WLAST)
                        state_d = WRESP;
                end
            end
            WRESP: begin
                if (b_hs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            rfirst_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            first_q  <= first_d;
            err_q    <= err_d;
            rfirst_q <= rfirst_d;
            rdata_q  <= rdata_d;
        end
    end

    // AXI outputs; readies are forced low while reset is held
    assign axi.AWREADY = ARESETn & st_idle;
    assign axi.ARREADY = ARESETn & st_idle & ~axi.AWVALID;
    assign axi.WREADY  = st_w;
    assign axi.BVALID  = st_b;
    assign axi.BID     = id_q;
    assign axi.BRESP   = (st_b & err_q) ? 2'b10 : 2'b00;
    assign axi.RVALID  = st_rd;
    assign axi.RID     = id_q;
    assign axi.RDATA   = st_rd ? rd_out : 32'h0;
    assign axi.RRESP   = (st_rd & err_q) ? 2'b10 : 2'b00;
    assign axi.RLAST   = st_rd & (cnt_q == 4'd0);

    // EPU bundle; an errored burst never touches the EPU
    assign inf_EPUIN.CS    = ok & (st_ra | st_rd | st_w | st_b);
    assign inf_EPUIN.OE    = ok & st_ra;
    assign inf_EPUIN.arhns = ok & st_ra & first_q;
    assign inf_EPUIN.awhns = ok & st_w & first_q;
    assign inf_EPUIN.whns  = ok & w_hs;
    assign inf_EPUIN.rhns  = ok & r_hs;
    assign inf_EPUIN.rdfin = ok & r_hs & (cnt_q == 4'd0);
    assign inf_EPUIN.wrfin = ok & b_hs;
    assign inf_EPUIN.addr  = addr_q;
    assign inf_EPUIN.wdata = (ok & st_w) ? axi.WDATA : 32'h0;
endmodule

// File: tb/tb_epu_axi_slave.sv
// Directed + randomized bench for epu_axi_slave. A simple EPU memory model
// sits on inf_EPUIN; a reference word array is updated from the AXI side
// and read bursts are compared against it.
module tb_epu_axi_slave;
    localparam int AW    = 16;
    localparam int DEPTH = 1 << AW;

    logic ACLK, ARESETn;
    epu_axi_if #(.IDW(8)) axi();
    epu_in_if  #(.EPU_AW(AW)) epu();

    epu_axi_slave #(.IDW(8), .EPU_AW(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi), .inf_EPUIN(epu)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int nchecks = 0;
    int nerr = 0;
    int n_arhns = 0, n_awhns = 0, n_whns = 0, n_rhns = 0, n_rdfin = 0, n_wrfin = 0;

    logic [31:0] mem     [0:DEPTH-1];  // EPU core storage
    logic [31:0] ref_mem [0:DEPTH-1];  // expected contents from AXI traffic

    // EPU core model: read data one cycle after CS&OE, garbage otherwise
    always @(posedge ACLK) begin
        if (epu.CS && epu.OE) epu.epu_rdata <= mem[epu.addr];
        else                  epu.epu_rdata <= $urandom;
        if (epu.whns) mem[epu.addr] <= epu.wdata;
    end

    // strobe pulse counters
    always @(posedge ACLK) begin
        if (epu.arhns) n_arhns <= n_arhns + 1;
        if (epu.awhns) n_awhns <= n_awhns + 1;
        if (epu.whns)  n_whns  <= n_whns + 1;
        if (epu.rhns)  n_rhns  <= n_rhns + 1;
        if (epu.rdfin) n_rdfin <= n_rdfin + 1;
        if (epu.wrfin) n_wrfin <= n_wrfin + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    function automatic bit burst_ok(input logic [1:0] b, input logic [2:0] s);
`ifdef EPU_SLVERR_EN
        return (b == 2'b01) && (s == 3'b010);
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_write(input logic [31:0] waddr, input int len, input logic [7:0] id,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] d0, input bit fixed, input bit gaps,
                            input int bdelay);
        bit ok;
        int n, a0, w0, f0;
        logic [AW-1:0] base, a;
        logic [31:0] d;
        ok = burst_ok(burst, size);
        base = AW'(waddr >> 2);
        a0 = n_awhns; w0 = n_whns; f0 = n_wrfin;
        axi.AWID = id; axi.AWADDR = waddr; axi.AWLEN = 4'(len);
        axi.AWSIZE = size; axi.AWBURST = burst; axi.AWVALID = 1'b1;
        #1;
        n = 0;
        while (!axi.AWREADY && n < 64) begin tick(); #1; n++; end
        chk("aw_ready", axi.AWREADY, 1);
        tick();
        axi.AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    axi.WVALID = 1'b0; #1;
                    chk("w_gap_whns", epu.whns, 0);
                    chk("w_gap_wready", axi.WREADY, 1);
                    tick();
                end
            end
            d = fixed ? d0 + 32'(i) : $urandom;
            a = base + AW'(i);
            axi.WVALID = 1'b1; axi.WDATA = d; axi.WLAST = (i == len); axi.WSTRB = 4'hF;
            #1;
            chk("wready", axi.WREADY, 1);
            chk("awhns", epu.awhns, (i == 0) && ok);
            chk("whns", epu.whns, ok);
            chk("cs_w", epu.CS, ok);
            chk("w_addr", epu.addr, a);
            if (ok) begin
                chk("wdata", epu.wdata, d);
                ref_mem[a] = d;
            end
            tick();
        end
        axi.WVALID = 1'b0; axi.WLAST = 1'b0;
        for (int k = bdelay; k >= 0; k--) begin
            axi.BREADY = (k == 0); #1;
            chk("bvalid", axi.BVALID, 1);
            chk("bid", axi.BID, id);
            chk("bresp", axi.BRESP, ok ? 2'b00 : 2'b10);
            chk("cs_b", epu.CS, ok);
            chk("wrfin", epu.wrfin, (k == 0) && ok);
            tick();
        end
        axi.BREADY = 1'b0;
        #1;
        chk("bvalid_drop", axi.BVALID, 0);
        chk("cs_idle_w", epu.CS, 0);
        chk("awhns_count", n_awhns - a0, ok ? 1 : 0);
        chk("whns_count", n_whns - w0, ok ? len + 1 : 0);
        chk("wrfin_count", n_wrfin - f0, ok ? 1 : 0);
    endtask

    task automatic do_read(input logic [31:0] raddr, input int len, input logic [7:0] id,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int stall_beat, input int stall_n, input bit expect_immediate);
        bit ok;
        int n, st, r0, h0, d0;
        logic [AW-1:0] base, a;
        logic [31:0] exp;
        ok = burst_ok(burst, size);
        base = AW'(raddr >> 2);
        r0 = n_arhns; h0 = n_rhns; d0 = n_rdfin;
        axi.ARID = id; axi.ARADDR = raddr; axi.ARLEN = 4'(len);
        axi.ARSIZE = size; axi.ARBURST = burst; axi.ARVALID = 1'b1;
        #1;
        if (expect_immediate) chk("ar_ready_now", axi.ARREADY, 1);
        n = 0;
        while (!axi.ARREADY && n < 64) begin tick(); #1; n++; end
        chk("ar_ready", axi.ARREADY, 1);
        tick();
        axi.ARVALID = 1'b0;
        #1;
        chk("arhns", epu.arhns, ok);
        chk("oe_first", epu.OE, ok);
        chk("cs_first", epu.CS, ok);
        chk("r_addr_first", epu.addr, base);
        chk("rvalid_early", axi.RVALID, 0);
        for (int i = 0; i <= len; i++) begin
            a = base + AW'(i);
            exp = ok ? ref_mem[a] : 32'h0;
            tick();
            st = (i == stall_beat) ? stall_n : $urandom_range(0, 1);
            for (int k = st; k >= 0; k--) begin
                axi.RREADY = (k == 0); #1;
                chk("rvalid", axi.RVALID, 1);
                chk("rdata", axi.RDATA, exp);
                chk("rlast", axi.RLAST, i == len);
                chk("rresp", axi.RRESP, ok ? 2'b00 : 2'b10);
                chk("rid", axi.RID, id);
                chk("r_addr_hold", epu.addr, a);
                chk("cs_rd", epu.CS, ok);
                chk("rhns", epu.rhns, (k == 0) && ok);
                chk("rdfin", epu.rdfin, (k == 0) && ok && (i == len));
                tick();
            end
            axi.RREADY = 1'b0;
            if (i < len) begin
                #1;
                chk("rvalid_gap", axi.RVALID, 0);
                chk("oe_next", epu.OE, ok);
                chk("arhns_once", epu.arhns, 0);
                chk("r_addr_next", epu.addr, a + AW'(1));
            end
        end
        #1;
        chk("rvalid_end", axi.RVALID, 0);
        chk("arhns_count", n_arhns - r0, ok ? 1 : 0);
        chk("rhns_count", n_rhns - h0, ok ? len + 1 : 0);
        chk("rdfin_count", n_rdfin - d0, ok ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_axi"}, {axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.BID,
                           axi.BRESP, axi.RVALID, axi.RID, axi.RRESP, axi.RLAST}, 0);
        chk({tag, "_rdata"}, axi.RDATA, 0);
        chk({tag, "_epu"}, {epu.CS, epu.OE, epu.arhns, epu.awhns, epu.whns, epu.rhns,
                           epu.rdfin, epu.wrfin, epu.addr}, 0);
        chk({tag, "_wdata"}, epu.wdata, 0);
    endtask

    initial begin
        logic [AW-1:0] wb;
        logic [31:0] hi, d;
        int ln, f0;

        ARESETn = 1'b0;
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
        axi.AWVALID = 1'b0;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0;
        axi.ARVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
        axi.BREADY = 1'b0; axi.RREADY = 1'b0;
        #13;
        check_zero("reset");
        tick(); tick();
        #2 ARESETn = 1'b1;
        tick(); #1;
        chk("idle_awready", axi.AWREADY, 1);
        chk("idle_arready", axi.ARREADY, 1);
        chk("idle_cs", epu.CS, 0);

        // single write then single read of 0x10 -> word 4
        do_write(32'h10, 0, 8'h11, 2'b01, 3'b010, 32'hDEADBEEF, 1, 0, 0);
        do_read(32'h10, 0, 8'h22, 2'b01, 3'b010, -1, 0, 0);

        // 4-beat write of 1..4 at 0x20, read back with a 5-cycle stall on beat 2
        do_write(32'h20, 3, 8'h33, 2'b01, 3'b010, 32'h1, 1, 0, 0);
        do_read(32'h20, 3, 8'h44, 2'b01, 3'b010, 1, 5, 0);

        // simultaneous AR/AW: write first, read right after wrfin
        tick();
        axi.ARID = 8'h66; axi.ARADDR = 32'h20; axi.ARLEN = 4'd3;
        axi.ARSIZE = 3'b010; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
        axi.AWVALID = 1'b1; axi.AWADDR = 32'h30;
        #1;
        chk("prio_arready", axi.ARREADY, 0);
        chk("prio_awready", axi.AWREADY, 1);
        f0 = n_arhns;
        do_write(32'h30, 1, 8'h55, 2'b01, 3'b010, 32'h0, 0, 1, 2);
        chk("prio_no_read", n_arhns - f0, 0);
        do_read(32'h20, 3, 8'h66, 2'b01, 3'b010, -1, 0, 1);

        // non-INCR / wrong-size bursts
        do_write(32'h200, 1, 8'h77, 2'b01, 3'b010, 32'h0, 0, 0, 0);
        do_write(32'h200, 1, 8'h78, 2'b00, 3'b010, 32'h0, 0, 0, 1);
        do_read(32'h200, 1, 8'h79, 2'b00, 3'b010, -1, 0, 0);
        do_read(32'h200, 1, 8'h7A, 2'b01, 3'b001, 0, 2, 0);
        do_read(32'h200, 1, 8'h7B, 2'b01, 3'b010, -1, 0, 0);

        // reset in the middle of a write burst
        tick();
        f0 = n_wrfin;
        axi.AWID = 8'h5A; axi.AWADDR = 32'h100; axi.AWLEN = 4'd3;
        axi.AWBURST = 2'b01; axi.AWSIZE = 3'b010; axi.AWVALID = 1'b1;
        #1;
        chk("mid_aw_ready", axi.AWREADY, 1);
        tick();
        axi.AWVALID = 1'b0;
        d = $urandom;
        axi.WVALID = 1'b1; axi.WDATA = d; axi.WLAST = 1'b0; #1;
        chk("mid_whns1", epu.whns, 1);
        ref_mem[AW'(32'h40)] = d;
        tick();
        axi.WDATA = $urandom; #1;
        chk("mid_whns2", epu.whns, 1);
        #2 ARESETn = 1'b0;
        #1;
        check_zero("midrst");
        axi.WVALID = 1'b0;
        tick(); tick();
        #2 ARESETn = 1'b1;
        tick(); #1;
        chk("midrst_no_wrfin", n_wrfin - f0, 0);
        chk("midrst_awready", axi.AWREADY, 1);
        do_write(32'h100, 3, 8'h5B, 2'b01, 3'b010, 32'h0, 0, 1, 1);
        do_read(32'h100, 3, 8'h5C, 2'b01, 3'b010, 2, 3, 0);

        // randomized bursts, upper address bits randomized, one wrap case
        for (int it = 0; it < 8; it++) begin
            wb = (it == 7) ? AW'(DEPTH - 3) : AW'($urandom);
            ln = $urandom_range(0, 15);
            hi = $urandom;
            do_write({hi[31:AW+2], wb, 2'b00}, ln, 8'($urandom), 2'b01, 3'b010,
                     32'h0, 0, 1, $urandom_range(0, 3));
            hi = $urandom;
            do_read({hi[31:AW+2], wb, 2'b00}, ln, 8'($urandom), 2'b01, 3'b010,
                    $urandom_range(0, ln), $urandom_range(0, 4), 0);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
